// File: rtl/uparc_muldiv.sv
// Iterative radix-2 multiply/divide unit with a private HI/LO pair (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Define UPARC_FAST_MULT_EN to replace the iterative multiply with a single-cycle multiplier.
module uparc_muldiv (
   input  logic        clk,
   input  logic        nrst,
   input  logic [2:0]  op,
   input  logic        start,
   input  logic        flush,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t      r_state;
   logic [4:0]  r_cnt;
   logic [63:0] r_acc;
   logic [31:0] r_opb;
   logic        r_is_div;
   logic        r_neg_q;
   logic        r_neg_r;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_sgn;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [32:0] w_mul_sum;
   logic [63:0] w_mul_next;
   logic        w_div_ge;
   logic [31:0] w_div_diff;
   logic [63:0] w_div_next;
   logic [63:0] w_mul_fix;
   logic [31:0] w_fix_hi;
   logic [31:0] w_fix_lo;

   // Signed ops (even op codes) work on magnitudes; signs are reapplied in FIX.
   assign w_sgn   = ~op[0];
   assign w_abs_a = (w_sgn && a[31]) ? (32'd0 - a) : a;
   assign w_abs_b = (w_sgn && b[31]) ? (32'd0 - b) : b;

   // Multiply step: conditionally add into the high half, then shift the whole accumulator right.
   assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_opb : 32'd0)};
   assign w_mul_next = {w_mul_sum, r_acc[31:1]};

   // Restoring divide step: the partial remainder can briefly need 33 bits after the shift.
   assign w_div_ge   = (r_acc[63:31] >= {1'b0, r_opb});
   assign w_div_diff = r_acc[62:31] - r_opb;
   assign w_div_next = w_div_ge ? {w_div_diff, r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};

   assign w_mul_fix = r_neg_q ? (64'd0 - r_acc) : r_acc;
   assign w_fix_hi  = r_is_div ? (r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32]) : w_mul_fix[63:32];
   assign w_fix_lo  = r_is_div ? (r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0]) : w_mul_fix[31:0];

`ifdef UPARC_FAST_MULT_EN
   logic [63:0] w_fast_prod;
   assign w_fast_prod = w_sgn ? ($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}))
                              : ({32'd0, a} * {32'd0, b});
`endif

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state  <= S_IDLE;
         r_cnt    <= 5'd0;
         r_acc    <= 64'd0;
         r_opb    <= 32'd0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
      end else begin
         r_done <= 1'b0;
         if (flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= 5'd0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     case (op)
                        3'd0, 3'd1: begin
`ifdef UPARC_FAST_MULT_EN
                           r_hi   <= w_fast_prod[63:32];
                           r_lo   <= w_fast_prod[31:0];
                           r_done <= 1'b1;
`else
                           r_acc    <= {32'd0, w_abs_a};
                           r_opb    <= w_abs_b;
                           r_neg_q  <= w_sgn & (a[31] ^ b[31]);
                           r_neg_r  <= w_sgn & a[31];
                           r_is_div <= 1'b0;
                           r_cnt    <= 5'd0;
                           r_busy   <= 1'b1;
                           r_state  <= S_CALC;
`endif
                        end
                        3'd2, 3'd3: begin
                           r_acc    <= {32'd0, w_abs_a};
                           r_opb    <= w_abs_b;
                           r_neg_q  <= w_sgn & (a[31] ^ b[31]);
                           r_neg_r  <= w_sgn & a[31];
                           r_is_div <= 1'b1;
                           r_cnt    <= 5'd0;
                           r_busy   <= 1'b1;
                           r_state  <= S_CALC;
                        end
                        3'd4: begin
                           r_hi   <= a;
                           r_done <= 1'b1;
                        end
                        3'd5: begin
                           r_lo   <= a;
                           r_done <= 1'b1;
                        end
                        default: begin
                        end
                     endcase
                  end
               end
               S_CALC: begin
                  r_acc <= r_is_div ? w_div_next : w_mul_next;
                  r_cnt <= r_cnt + 5'd1;
                  if (r_cnt == 5'd31) begin
                     r_state <= S_FIX;
                  end
               end
               S_FIX: begin
                  r_hi    <= w_fix_hi;
                  r_lo    <= w_fix_lo;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_uparc_muldiv.sv
// Directed self-checking bench for uparc_muldiv; expected values are hand-computed constants.
module tb_uparc_muldiv;

`ifdef UPARC_FAST_MULT_EN
   localparam int MUL_LAT  = 1;
   localparam int MUL_BUSY = 0;
`else
   localparam int MUL_LAT  = 34;
   localparam int MUL_BUSY = 33;
`endif
   localparam int DIV_LAT  = 34;
   localparam int DIV_BUSY = 33;

   logic        clk;
   logic        nrst;
   logic [2:0]  op;
   logic        start;
   logic        flush;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int tests_run;
   int tests_failed;

   uparc_muldiv dut (
      .clk   (clk),
      .nrst  (nrst),
      .op    (op),
      .start (start),
      .flush (flush),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a negedge: present a request for one cycle.
   task automatic issue(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b);
      op    = t_op;
      a     = t_a;
      b     = t_b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts cycles until done (lat = -1 on timeout) and busy cycles seen before it.
   task automatic wait_done(output int lat, output int nbusy);
      lat   = -1;
      nbusy = 0;
      for (int i = 1; i <= 80; i++) begin
         @(negedge clk);
         if (busy) nbusy++;
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      nrst = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
      repeat (3) @(negedge clk);
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy); end
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b exp 0", done); end
      tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("FAIL reset_hi got %h exp 0", hi); end
      tests_run++; if (lo !== 32'd0) begin tests_failed++; $display("FAIL reset_lo got %h exp 0", lo); end
      nrst = 1'b1;
      repeat (4) @(negedge clk);
      tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL idle_after_reset busy=%b done=%b exp 0/0", busy, done); end
   endtask

   task automatic test_mult();
      int lat, nb;
      issue(3'd0, 32'hFFFFFFFE, 32'd3);
      wait_done(lat, nb);
      tests_run++; if (lat != MUL_LAT) begin tests_failed++; $display("FAIL mult_latency got %0d exp %0d", lat, MUL_LAT); end
      tests_run++; if (nb != MUL_BUSY) begin tests_failed++; $display("FAIL mult_busy_cycles got %0d exp %0d", nb, MUL_BUSY); end
      tests_run++; if (hi !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
      tests_run++; if (lo !== 32'hFFFFFFFA) begin tests_failed++; $display("FAIL mult_lo got %h exp fffffffa", lo); end
      @(negedge clk);
      issue(3'd1, 32'hFFFFFFFE, 32'd3);
      wait_done(lat, nb);
      tests_run++; if (lat != MUL_LAT) begin tests_failed++; $display("FAIL multu_latency got %0d exp %0d", lat, MUL_LAT); end
      tests_run++; if (hi !== 32'h00000002) begin tests_failed++; $display("FAIL multu_hi got %h exp 00000002", hi); end
      tests_run++; if (lo !== 32'hFFFFFFFA) begin tests_failed++; $display("FAIL multu_lo got %h exp fffffffa", lo); end
   endtask

   task automatic test_div();
      int lat, nb;
      issue(3'd2, 32'hFFFFFFF9, 32'd2);
      wait_done(lat, nb);
      tests_run++; if (lat != DIV_LAT) begin tests_failed++; $display("FAIL div_latency got %0d exp %0d", lat, DIV_LAT); end
      tests_run++; if (nb != DIV_BUSY) begin tests_failed++; $display("FAIL div_busy_cycles got %0d exp %0d", nb, DIV_BUSY); end
      tests_run++; if (lo !== 32'hFFFFFFFD) begin tests_failed++; $display("FAIL div_lo got %h exp fffffffd", lo); end
      tests_run++; if (hi !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL div_hi got %h exp ffffffff", hi); end
      @(negedge clk);
      issue(3'd3, 32'd7, 32'd0);
      wait_done(lat, nb);
      tests_run++; if (lat != DIV_LAT) begin tests_failed++; $display("FAIL divu0_latency got %0d exp %0d", lat, DIV_LAT); end
      tests_run++; if (lo !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL divu0_lo got %h exp ffffffff", lo); end
      tests_run++; if (hi !== 32'd7) begin tests_failed++; $display("FAIL divu0_hi got %h exp 00000007", hi); end
      @(negedge clk);
      issue(3'd2, 32'hFFFFFFF9, 32'd0);
      wait_done(lat, nb);
      tests_run++; if (lo !== 32'h00000001) begin tests_failed++; $display("FAIL div0_neg_lo got %h exp 00000001", lo); end
      tests_run++; if (hi !== 32'hFFFFFFF9) begin tests_failed++; $display("FAIL div0_neg_hi got %h exp fffffff9", hi); end
   endtask

   task automatic test_back_to_back();
      int lat, nb;
      @(negedge clk);
      issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
      wait_done(lat, nb);
      tests_run++; if (lo !== 32'h80000000) begin tests_failed++; $display("FAIL div_ovf_lo got %h exp 80000000", lo); end
      tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("FAIL div_ovf_hi got %h exp 00000000", hi); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL done_cycle_busy got %b exp 0", busy); end
      // Second request issued in the done cycle itself.
      issue(3'd3, 32'd100, 32'd7);
      @(negedge clk);
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_busy got %b exp 1", busy); end
      wait_done(lat, nb);
      tests_run++; if (lat != DIV_LAT - 1) begin tests_failed++; $display("FAIL b2b_latency got %0d exp %0d", lat, DIV_LAT - 1); end
      tests_run++; if (lo !== 32'd14 || hi !== 32'd2) begin tests_failed++; $display("FAIL b2b_result got hi=%h lo=%h exp 2/e", hi, lo); end
   endtask

   task automatic test_mthi_mtlo();
      int lat, nb;
      @(negedge clk);
      issue(3'd4, 32'h12345678, 32'd0);
      wait_done(lat, nb);
      tests_run++; if (lat != 1) begin tests_failed++; $display("FAIL mthi_latency got %0d exp 1", lat); end
      tests_run++; if (nb != 0) begin tests_failed++; $display("FAIL mthi_busy got %0d exp 0", nb); end
      tests_run++; if (hi !== 32'h12345678) begin tests_failed++; $display("FAIL mthi_hi got %h exp 12345678", hi); end
      tests_run++; if (lo !== 32'd14) begin tests_failed++; $display("FAIL mthi_lo_kept got %h exp 0000000e", lo); end
      issue(3'd5, 32'hCAFEBABE, 32'd0);
      wait_done(lat, nb);
      tests_run++; if (lo !== 32'hCAFEBABE || hi !== 32'h12345678) begin tests_failed++; $display("FAIL mtlo got hi=%h lo=%h exp 12345678/cafebabe", hi, lo); end
      // Reserved op: nothing happens.
      issue(3'd7, 32'h0BADF00D, 32'd1);
      @(negedge clk);
      tests_run++; if (done !== 1'b0 || busy !== 1'b0 || lo !== 32'hCAFEBABE) begin tests_failed++; $display("FAIL reserved_op done=%b busy=%b lo=%h exp 0/0/cafebabe", done, busy, lo); end
   endtask

   task automatic test_busy_ignore();
      int lat;
      lat = -1;
      issue(3'd3, 32'd100, 32'd7);
      for (int i = 1; i <= 80; i++) begin
         @(negedge clk);
         if (i == 5) begin
            op = 3'd4; a = 32'hDEADBEEF; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (i == 10) begin
            tests_run++; if (hi !== 32'h12345678 || lo !== 32'hCAFEBABE) begin tests_failed++; $display("FAIL hold_during_calc got hi=%h lo=%h exp 12345678/cafebabe", hi, lo); end
         end
         if (done) begin
            lat = i;
            break;
         end
      end
      start = 1'b0;
      tests_run++; if (lat != DIV_LAT) begin tests_failed++; $display("FAIL ignore_latency got %0d exp %0d", lat, DIV_LAT); end
      tests_run++; if (hi !== 32'd2 || lo !== 32'd14) begin tests_failed++; $display("FAIL ignore_result got hi=%h lo=%h exp 2/e", hi, lo); end
      @(negedge clk);
      tests_run++; if (done !== 1'b0 || hi !== 32'd2) begin tests_failed++; $display("FAIL ignore_no_side_effect done=%b hi=%h exp 0/2", done, hi); end
   endtask

   task automatic test_flush();
      int lat, nb, ndone;
      issue(3'd3, 32'hFFFFFFFF, 32'd3);
      for (int i = 1; i <= 11; i++) @(negedge clk);
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL flush_pre_busy got %b exp 1", busy); end
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_busy got %b exp 0", busy); end
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      tests_run++; if (ndone != 0) begin tests_failed++; $display("FAIL flush_no_done got %0d pulses exp 0", ndone); end
      tests_run++; if (hi !== 32'd2 || lo !== 32'd14) begin tests_failed++; $display("FAIL flush_keep got hi=%h lo=%h exp 2/e", hi, lo); end
      // Flush and start together: flush wins.
      flush = 1'b1;
      issue(3'd4, 32'h00000055, 32'd0);
      flush = 1'b0;
      @(negedge clk);
      tests_run++; if (done !== 1'b0 || hi !== 32'd2) begin tests_failed++; $display("FAIL flush_start_mthi done=%b hi=%h exp 0/2", done, hi); end
      flush = 1'b1;
      issue(3'd3, 32'd9, 32'd2);
      flush = 1'b0;
      @(negedge clk);
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_start_divu busy=%b exp 0", busy); end
      // Unit still operational afterwards.
      issue(3'd1, 32'h00010000, 32'h00010000);
      wait_done(lat, nb);
      tests_run++; if (lat != MUL_LAT || hi !== 32'd1 || lo !== 32'd0) begin tests_failed++; $display("FAIL post_flush_multu lat=%0d hi=%h lo=%h exp %0d/1/0", lat, hi, lo, MUL_LAT); end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      issue(3'd3, 32'd1000, 32'd3);
      repeat (5) @(negedge clk);
      nrst = 1'b0;
      #1;
      tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL async_reset_ctl busy=%b done=%b exp 0/0", busy, done); end
      tests_run++; if (hi !== 32'd0 || lo !== 32'd0) begin tests_failed++; $display("FAIL async_reset_data hi=%h lo=%h exp 0/0", hi, lo); end
      @(negedge clk);
      nrst = 1'b1;
      repeat (40) @(negedge clk);
      tests_run++; if (done !== 1'b0 || hi !== 32'd0) begin tests_failed++; $display("FAIL after_async_reset done=%b hi=%h exp 0/0", done, hi); end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_mult();
      test_div();
      test_back_to_back();
      test_mthi_mtlo();
      test_busy_ignore();
      test_flush();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/uparc_muldiv.md
# uparc_muldiv

Sequential multiply/divide unit of the execute stage, operating alongside the ALU on the same register operands. It performs MULT, MULTU, DIV, DIVU into a private HI/LO register pair, and services MTHI/MTLO writes. The pipeline control reads HI/LO through MFHI/MFLO forwarding and stalls on `busy`. Multiply and divide are iterative radix-2, one bit per cycle.

## Interface
- No parameters. Data width is `UPARC_REG_WIDTH` (32).
- clk  input  1  core clock; all state changes on its rising edge
- nrst  input  1  reset, asynchronous, active-low
- op  input  3  operation select, sampled with `start`: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 reserved (no-op)
- start  input  1  request; accepted only when `busy`=0 and `flush`=0
- flush  input  1  synchronous abort from exception/pipeline flush
- a  input  32  rs operand (multiplicand / dividend / MTHI/MTLO data)
- b  input  32  rt operand (multiplier / divisor)
- busy  output  1  operation in progress; new `start` ignored
- done  output  1  one-cycle pulse; `hi`/`lo` hold the new result in this cycle
- hi  output  32  HI register (product high word / remainder)
- lo  output  32  LO register (product low word / quotient)

## Operation
- States: IDLE, CALC, FIX.
- IDLE + accepted MULT/MULTU/DIV/DIVU: capture |a|, |b| (signed ops) or raw a, b (unsigned ops), result signs (product sign = a[31]^b[31]; quotient sign likewise; remainder sign = a[31]); clear 5-bit counter; go to CALC.
- CALC: 32 iterations, counter 0..31.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract.
  - At counter 31, go to FIX.
- FIX: apply two's-complement negation per captured signs; write `hi`/`lo`; go to IDLE. `done` is registered high for the next cycle.
- MTHI/MTLO accepted in IDLE: write `a` to `hi`/`lo` at that edge. `done` pulses the next cycle. No busy cycle.
- Reserved op accepted: no state change, no `done`.
- Divide by zero: no special path. The algorithm yields `lo`=0xFFFFFFFF (DIVU) or ±0xFFFFFFFF after sign fix (DIV: `lo`=0x00000001 if a negative, else 0xFFFFFFFF), and `hi`=a. Latency is normal.
- DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- `flush` in any state: return to IDLE next edge. `hi`/`lo` unchanged, no `done`. `flush`+`start` in the same cycle: `flush` wins.
- `start` while `busy`=1: ignored, with no side effects.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- Iterative op, start sampled at the edge ending cycle T:
  - `busy`=1 in cycles T+1..T+33 (CALC T+1..T+32, FIX T+33).
  - `done`=1 and new `hi`/`lo` in cycle T+34, with `busy`=0.
  - A new `start` is accepted in cycle T+34 (back-to-back).
- MTHI/MTLO at T: new value visible and `done`=1 in cycle T+1.
- `hi`/`lo` change only at FIX completion or MTHI/MTLO. They are stable during CALC and hold previous results.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous).

## Configuration
- `UPARC_FAST_MULT_EN` defined:
  - MULT/MULTU use a single-cycle combinational 32×32 signed/unsigned multiplier.
  - Start at T: `hi`/`lo` written at that edge, `done`=1 in T+1, `busy` never asserted.
  - DIV/DIVU are unchanged.
- Not defined: MULT/MULTU use the iterative path with 34-cycle latency as above.

## Test plan
- Reset: hold `nrst`=0 → `busy`=0, `done`=0, `hi`=0, `lo`=0. Release → remain until `start`.
- MULT a=0xFFFFFFFE (-2), b=3 → `done` at T+34 (T+1 with fast mult): `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. MULTU same operands → `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU a=7, b=0 → `lo`=0xFFFFFFFF, `hi`=7, latency 34.
- DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0. Issue a second `start` in the `done` cycle → accepted, `busy`=1 the next cycle.
- MTHI a=0x12345678 → `hi`=0x12345678 and `done`=1 next cycle, `lo` unchanged. `start` during `busy` → ignored, original result unaffected.
- DIVU running, `flush` at CALC counter 10 → IDLE next cycle, no `done`, `hi`/`lo` keep prior values. `flush`+`start` together → no operation started.
